bcd_mod_counter: RTL and testbench
==================================

# bcd_mod_counter

Parametrised multi-digit BCD counter with a programmable range LOW..HIGH, up/down counting, validated parallel load, a wrap pulse and a combinational terminal-count output for cascading. It is the generic building block for the clock's time-of-day and calendar fields: seconds/minutes (0..59), hours (0..23 or 1..12) and days (1..31). It replaces the fixed per-modulus counters and is chained stage to stage through `o_tc` and `i_ena`.

## Interface
- `DIGITS`, default 2: number of BCD digits, legal range 1..4.
- `LOW`, default 0: lowest count value, decimal integer.
- `HIGH`, default 11: highest count value, decimal integer. Constraint: 0 <= LOW < HIGH <= 10^DIGITS-1.
- `i_clk`, input, 1: system clock; all state changes on its rising edge.
- `i_reset`, input, 1: synchronous, active-high reset.
- `i_ena`, input, 1: count enable; one step per clock cycle in which it is high.
- `i_dn`, input, 1: direction; 0 counts up, 1 counts down. Sampled with `i_ena`.
- `i_wr`, input, 1: parallel load strobe.
- `i_in`, input, 4*DIGITS: BCD load value; digit 0 is in bits [3:0].
- `o_q`, output, 4*DIGITS: registered BCD count.
- `o_tc`, output, 1: combinational terminal count. High when `o_q`==HIGH and `i_dn`=0, or `o_q`==LOW and `i_dn`=1.
- `o_out`, output, 1: registered wrap pulse.
- `o_err`, output, 1: registered pulse flagging a rejected load.

## Operation
- Priority on each edge is `i_reset` > `i_wr` > `i_ena`.
- Reset:
  - Acts regardless of `i_ena`.
  - `o_q` = BCD(LOW), `o_out` = 0, `o_err` = 0.
- Load (`i_wr`=1):
  - Acts regardless of `i_ena`.
  - The value is accepted when every digit is <= 9 and LOW <= value <= HIGH; `o_q` then takes `i_in`.
  - Otherwise `o_q` holds and `o_err`=1 for one cycle.
  - A load never asserts `o_out`. A simultaneous `i_ena` is ignored.
- Count up (`i_ena`=1, `i_dn`=0):
  - If `o_q`==HIGH, `o_q` becomes LOW and `o_out`=1 on the next cycle.
  - Otherwise `o_q` increments by 1 in BCD: a digit at 9 goes to 0 and carries into the next digit.
- Count down (`i_ena`=1, `i_dn`=1):
  - If `o_q`==LOW, `o_q` becomes HIGH and `o_out`=1 on the next cycle.
  - Otherwise `o_q` decrements in BCD: a digit at 0 goes to 9 and borrows from the next digit.
- Idle (`i_ena`=0, no `i_wr`): `o_q` holds.
- `o_out` and `o_err` are high for exactly one cycle per event; otherwise 0.
- Cascading: the next stage is driven with `i_ena` = upstream `i_ena & o_tc` and the same `i_dn`. The chain then steps atomically on the same edge as the upstream wrap, with no skew.
- Internal representation is BCD only. Range comparisons use BCD constants derived from LOW and HIGH at elaboration time; no binary-to-BCD conversion at runtime.
- `o_q` never holds a value outside LOW..HIGH or an invalid BCD digit after reset.

## Timing
- Latency:
  - `o_q` changes on the edge that samples `i_ena`/`i_wr`, i.e. 1 cycle.
  - `o_out` and `o_err` assert in the cycle after that edge, coincident with the new `o_q` value.
- `o_tc` is combinational from `o_q` and `i_dn`, with no register delay. Changing `i_dn` changes `o_tc` in the same cycle.
- Reset mid-count:
  - `o_q` = LOW on the next edge.
  - A pending `o_out`/`o_err` pulse is cleared on that edge, not emitted.
- Back-to-back wraps: `i_ena` high every cycle with HIGH-LOW+1 = N gives one `o_out` pulse every N cycles.
- Direction change with `i_ena` held high takes effect on the same edge; no dead cycle.

## Test plan
- Defaults (LOW=0, HIGH=11): reset, then 12 enables up.
  - `o_q` steps 00..11, then 00.
  - `o_out`=1 only in the cycle showing 00.
  - `o_tc`=1 only while `o_q`=11.
- Down wrap: reset, `i_dn`=1, one enable.
  - `o_q`=11 with `o_out`=1.
  - Next enable gives 10 and `o_out`=0.
- Loads:
  - `i_in`=07 gives `o_q`=07, then one enable up gives 08.
  - `i_in`=13 gives `o_q` held and `o_err`=1.
  - `i_in`=0x1A (invalid digit) gives `o_q` held and `o_err`=1.
- Simultaneous events:
  - `i_wr`(05) and `i_ena` on the same edge give `o_q`=05 with no step.
  - `i_reset`, `i_wr` and `i_ena` all high give `o_q`=00.
- Reset with `o_q`=11 and `i_ena` high gives `o_q`=00, with no `o_out` pulse in the following cycle.
- Cascade: stage A (0..59) drives stage B (LOW=1, HIGH=12) with B `i_ena` = A `i_ena` & A `o_tc`.
  - A=59, B=12 plus one enable gives A=00, B=01 on the same edge.
  - B `o_out`=1.

Source files
------------

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD counter with a programmable LOW..HIGH range, up/down stepping,
// validated parallel load, a wrap pulse and a combinational terminal count for chaining.
module bcd_mod_counter #(
    parameter int DIGITS = 2,
    parameter int LOW    = 0,
    parameter int HIGH   = 11
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ena,
    input  logic                  i_dn,
    input  logic                  i_wr,
    input  logic [4*DIGITS-1:0]   i_in,
    output logic [4*DIGITS-1:0]   o_q,
    output logic                  o_tc,
    output logic                  o_out,
    output logic                  o_err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Range bounds exist only as BCD constants; nothing is converted at runtime.
    localparam logic [W-1:0] LOW_BCD  = to_bcd(LOW);
    localparam logic [W-1:0] HIGH_BCD = to_bcd(HIGH);

    logic [W-1:0] r_q;
    logic         r_out;
    logic         r_err;

    logic [W-1:0] w_inc;
    logic [W-1:0] w_dec;
    logic         w_digits_ok;
    logic         w_in_range;
    logic         w_load_ok;
    logic         w_at_low;
    logic         w_at_high;

    always_comb begin
        logic v_carry;
        w_inc   = r_q;
        v_carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (v_carry) begin
                if (r_q[4*d +: 4] == 4'd9) begin
                    w_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_inc[4*d +: 4] = r_q[4*d +: 4] + 4'd1;
                    v_carry         = 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic v_borrow;
        w_dec    = r_q;
        v_borrow = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (v_borrow) begin
                if (r_q[4*d +: 4] == 4'd0) begin
                    w_dec[4*d +: 4] = 4'd9;
                end else begin
                    w_dec[4*d +: 4] = r_q[4*d +: 4] - 4'd1;
                    v_borrow        = 1'b0;
                end
            end
        end
    end

    // With every digit <= 9, plain unsigned ordering of the BCD word matches decimal ordering.
    always_comb begin
        w_digits_ok = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (i_in[4*d +: 4] > 4'd9) begin
                w_digits_ok = 1'b0;
            end
        end
    end

    assign w_in_range = (i_in >= LOW_BCD) && (i_in <= HIGH_BCD);
    assign w_load_ok  = w_digits_ok && w_in_range;
    assign w_at_low   = (r_q == LOW_BCD);
    assign w_at_high  = (r_q == HIGH_BCD);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q   <= LOW_BCD;
            r_out <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_out <= 1'b0;
            r_err <= 1'b0;
            if (i_wr) begin
                if (w_load_ok) begin
                    r_q <= i_in;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (i_ena) begin
                if (i_dn) begin
                    if (w_at_low) begin
                        r_q   <= HIGH_BCD;
                        r_out <= 1'b1;
                    end else begin
                        r_q <= w_dec;
                    end
                end else begin
                    if (w_at_high) begin
                        r_q   <= LOW_BCD;
                        r_out <= 1'b1;
                    end else begin
                        r_q <= w_inc;
                    end
                end
            end
        end
    end

    // Terminal count stays combinational so a downstream stage steps on the same edge as the wrap.
    assign o_tc  = i_dn ? w_at_low : w_at_high;
    assign o_q   = r_q;
    assign o_out = r_out;
    assign o_err = r_err;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: vector table on a default 0..11 instance,
// plus hand sequences for back-to-back wraps and a two-stage 0..59 -> 1..12 cascade.
module tb_bcd_mod_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, wr, ena, dn;
    logic [7:0] din;
    logic [7:0] q;
    logic       tc, out, err;

    bcd_mod_counter dut (
        .i_clk(clk), .i_reset(rst), .i_ena(ena), .i_dn(dn), .i_wr(wr),
        .i_in(din), .o_q(q), .o_tc(tc), .o_out(out), .o_err(err)
    );

    logic       a_rst, a_wr, a_ena, a_dn;
    logic [7:0] a_in, a_q, b_in, b_q;
    logic       a_tc, a_out, a_err, b_tc, b_out, b_err, b_wr;
    logic       b_ena;
    assign b_ena = a_ena & a_tc;

    bcd_mod_counter #(.DIGITS(2), .LOW(0), .HIGH(59)) u_a (
        .i_clk(clk), .i_reset(a_rst), .i_ena(a_ena), .i_dn(a_dn), .i_wr(a_wr),
        .i_in(a_in), .o_q(a_q), .o_tc(a_tc), .o_out(a_out), .o_err(a_err)
    );

    bcd_mod_counter #(.DIGITS(2), .LOW(1), .HIGH(12)) u_b (
        .i_clk(clk), .i_reset(a_rst), .i_ena(b_ena), .i_dn(a_dn), .i_wr(b_wr),
        .i_in(b_in), .o_q(b_q), .o_tc(b_tc), .o_out(b_out), .o_err(b_err)
    );

    typedef struct {
        logic       rst, wr, ena, dn;
        logic [7:0] din;
        logic [7:0] q;
        logic       out, err, tc;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic w, input logic e, input logic d,
                       input logic [7:0] i, input logic [7:0] eq,
                       input logic eo, input logic ee, input logic et);
        vecs[nv].rst = r; vecs[nv].wr = w; vecs[nv].ena = e; vecs[nv].dn = d;
        vecs[nv].din = i; vecs[nv].q = eq;
        vecs[nv].out = eo; vecs[nv].err = ee; vecs[nv].tc = et;
        nv++;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int pulses, first_pulse, second_pulse;

        rst = 1'b1; wr = 1'b0; ena = 1'b0; dn = 1'b0; din = 8'h00;
        a_rst = 1'b1; a_wr = 1'b0; b_wr = 1'b0; a_ena = 1'b0; a_dn = 1'b0;
        a_in = 8'h00; b_in = 8'h00;

        //   rst wr ena dn  in     q      out err tc
        add(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h02, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h03, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h04, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h05, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h06, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h07, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h08, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h09, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h10, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h11, 0, 0, 1);
        add(0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 0);
        add(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 1, 1, 8'h00, 8'h11, 1, 0, 0);
        add(0, 0, 1, 1, 8'h00, 8'h10, 0, 0, 0);
        add(0, 0, 1, 1, 8'h00, 8'h09, 0, 0, 0);
        add(0, 0, 0, 0, 8'h00, 8'h09, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h10, 0, 0, 0);
        add(0, 1, 0, 0, 8'h07, 8'h07, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 8'h08, 0, 0, 0);
        add(0, 1, 0, 0, 8'h13, 8'h08, 0, 1, 0);
        add(0, 1, 0, 0, 8'h1A, 8'h08, 0, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'h08, 0, 0, 0);
        add(0, 1, 1, 0, 8'h05, 8'h05, 0, 0, 0);
        add(1, 1, 1, 0, 8'h07, 8'h00, 0, 0, 0);
        add(0, 1, 0, 0, 8'h11, 8'h11, 0, 0, 1);
        add(0, 0, 0, 1, 8'h00, 8'h11, 0, 0, 0);
        add(1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1);
        add(0, 1, 1, 1, 8'h00, 8'h00, 0, 0, 1);
        add(0, 1, 0, 1, 8'h0B, 8'h00, 0, 1, 1);
        add(0, 1, 0, 0, 8'h12, 8'h00, 0, 1, 0);

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; wr = vecs[i].wr; ena = vecs[i].ena;
            dn = vecs[i].dn; din = vecs[i].din;
            @(posedge clk); #1;
            chk($sformatf("v%0d_q", i),   q,          vecs[i].q);
            chk($sformatf("v%0d_out", i), {7'd0, out}, {7'd0, vecs[i].out});
            chk($sformatf("v%0d_err", i), {7'd0, err}, {7'd0, vecs[i].err});
            chk($sformatf("v%0d_tc", i),  {7'd0, tc},  {7'd0, vecs[i].tc});
        end

        // Back-to-back wraps: 24 consecutive up steps from 00 give pulses 12 cycles apart.
        @(negedge clk);
        rst = 1'b1; wr = 1'b0; ena = 1'b0; dn = 1'b0;
        @(negedge clk);
        rst = 1'b0; ena = 1'b1;
        pulses = 0; first_pulse = -1; second_pulse = -1;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (out) begin
                if (pulses == 0) first_pulse = c;
                else if (pulses == 1) second_pulse = c;
                pulses++;
            end
        end
        @(negedge clk);
        ena = 1'b0;
        chk("b2b_pulses", 8'(pulses), 8'd2);
        chk("b2b_first", 8'(first_pulse), 8'd11);
        chk("b2b_spacing", 8'(second_pulse - first_pulse), 8'd12);

        // Cascade: A 0..59 feeds B 1..12 through A's terminal count.
        @(negedge clk);
        a_rst = 1'b1;
        @(posedge clk); #1;
        chk("casc_b_reset", b_q, 8'h01);
        @(negedge clk);
        a_rst = 1'b0; a_wr = 1'b1; a_in = 8'h59; b_wr = 1'b1; b_in = 8'h12;
        @(posedge clk); #1;
        chk("casc_a_load", a_q, 8'h59);
        chk("casc_b_load", b_q, 8'h12);
        @(negedge clk);
        a_wr = 1'b0; b_wr = 1'b0; a_ena = 1'b1;
        #1;
        chk("casc_a_tc", {7'd0, a_tc}, 8'd1);
        @(posedge clk); #1;
        chk("casc_a_wrap", a_q, 8'h00);
        chk("casc_b_wrap", b_q, 8'h01);
        chk("casc_a_out", {7'd0, a_out}, 8'd1);
        chk("casc_b_out", {7'd0, b_out}, 8'd1);
        @(posedge clk); #1;
        chk("casc_a_step", a_q, 8'h01);
        chk("casc_b_hold", b_q, 8'h01);
        chk("casc_b_out_clr", {7'd0, b_out}, 8'd0);
        @(negedge clk);
        a_ena = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
